// File: rtl/scan_letter_fifo_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the PS/2 scan-code-to-letter FIFO:
//   - PS/2 set-2 make codes for the letters A..Z
//   - F0 (break) and E0 (extended) prefix byte constants
//   - decoder FSM state type
//   - code_to_letter(): maps one set-2 byte to a letter index (A=0 .. Z=25)
// Optional feature macro used by the design: SCAN_TYPEMATIC_FILTER_EN
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int LETTER_W    = 5;

  // Prefix bytes
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E0 = 8'hE0;

  // Set-2 make codes for letters
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;

  // Decoder states: IDLE waits for a make or a prefix, BRK swallows the byte
  // after F0, EXT swallows the byte after E0 (unless it is F0), EXT_BRK
  // swallows the byte after E0 F0.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic                hit;
    logic [LETTER_W-1:0] idx;
  } letter_lookup_t;

  function automatic letter_lookup_t code_to_letter(input logic [7:0] code);
    letter_lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case (code)
      SC_A: r.idx = 5'd0;
      SC_B: r.idx = 5'd1;
      SC_C: r.idx = 5'd2;
      SC_D: r.idx = 5'd3;
      SC_E: r.idx = 5'd4;
      SC_F: r.idx = 5'd5;
      SC_G: r.idx = 5'd6;
      SC_H: r.idx = 5'd7;
      SC_I: r.idx = 5'd8;
      SC_J: r.idx = 5'd9;
      SC_K: r.idx = 5'd10;
      SC_L: r.idx = 5'd11;
      SC_M: r.idx = 5'd12;
      SC_N: r.idx = 5'd13;
      SC_O: r.idx = 5'd14;
      SC_P: r.idx = 5'd15;
      SC_Q: r.idx = 5'd16;
      SC_R: r.idx = 5'd17;
      SC_S: r.idx = 5'd18;
      SC_T: r.idx = 5'd19;
      SC_U: r.idx = 5'd20;
      SC_V: r.idx = 5'd21;
      SC_W: r.idx = 5'd22;
      SC_X: r.idx = 5'd23;
      SC_Y: r.idx = 5'd24;
      SC_Z: r.idx = 5'd25;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scan_letter_fifo_if.sv
// -----------------------------------------------------------------------------
// scan_letter_fifo_if
// Bundle of the scan-code input strobe, FIFO control and letter outputs.
//   master : keyboard/consumer side (drives scan_code, scan_valid, clear, pop)
//   slave  : scan_letter_fifo (drives letter, letter_onehot, out_valid,
//            count, overflow)
// Parameters: DEPTH (FIFO entries), CODE_W (scan-code width, >= 8)
// -----------------------------------------------------------------------------
interface scan_letter_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [CODE_W-1:0]  scan_code;
  logic               scan_valid;
  logic               clear;
  logic               pop;
  logic [4:0]         letter;
  logic [25:0]        letter_onehot;
  logic               out_valid;
  logic [COUNT_W-1:0] count;
  logic               overflow;

  modport master (
    output scan_code, scan_valid, clear, pop,
    input  letter, letter_onehot, out_valid, count, overflow
  );

  modport slave (
    input  scan_code, scan_valid, clear, pop,
    output letter, letter_onehot, out_valid, count, overflow
  );
endinterface

// File: rtl/scan_letter_fifo_fifo.sv
// -----------------------------------------------------------------------------
// letter_fifo
// Circular FIFO of letter indices with occupancy counter.
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   clear         : synchronous flush (wins over push/pop)
//   push, din     : write request and data
//   pop           : read request (ignored when empty)
//   dout          : head entry, forced to 0 when empty
//   count         : occupancy 0..DEPTH
//   empty         : no entries
//   dropped       : push refused this cycle because full with no pop
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width)
// -----------------------------------------------------------------------------
module letter_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       dropped
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == COUNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop) && !clear;
  assign dropped = push && full && !do_pop && !clear;

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Asynchronous read of the head keeps push-to-visible latency at one cycle.
  assign dout  = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/scan_letter_fifo.sv
// -----------------------------------------------------------------------------
// scan_letter_fifo
// Decodes a stream of PS/2 set-2 bytes into letter indices (A=0 .. Z=25)
// and queues them in a FIFO for a consumer.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : scan_letter_fifo_if.slave
//            in : scan_code, scan_valid (strobe), clear (sync flush), pop
//            out: letter (head, 0 when empty), letter_onehot, out_valid,
//                 count, overflow (sticky drop flag)
// Parameters: DEPTH (power of 2, >= 2), CODE_W (>= 8)
// Optional feature: define SCAN_TYPEMATIC_FILTER_EN to suppress auto-repeat
// makes of the currently held letter.
// -----------------------------------------------------------------------------
module scan_letter_fifo
  import scan_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
) (
  input logic                clock,
  input logic                resetn,
  scan_letter_fifo_if.slave  bus
);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  dec_state_t          state_reg;
  dec_state_t          state_next;
  logic                overflow_reg;
  logic                push_req;
  logic [LETTER_W-1:0] push_letter;

  logic [7:0]          code_byte;
  logic                code_is_byte;
  letter_lookup_t      lookup;
  logic                is_f0;
  logic                is_e0;
  logic                is_letter;

  logic [LETTER_W-1:0] head_letter;
  logic [COUNT_W-1:0]  fifo_count;
  logic                fifo_empty;
  logic                fifo_dropped;

`ifdef SCAN_TYPEMATIC_FILTER_EN
  logic                held_valid_reg;
  logic                held_valid_next;
  logic [LETTER_W-1:0] held_letter_reg;
  logic [LETTER_W-1:0] held_letter_next;
`endif

  // Wider codes only match when the bits above the set-2 byte are zero.
  assign code_byte    = bus.scan_code[7:0];
  assign code_is_byte = ((bus.scan_code >> 8) == '0);
  assign lookup       = code_to_letter(code_byte);
  assign is_f0        = code_is_byte && (code_byte == SC_F0);
  assign is_e0        = code_is_byte && (code_byte == SC_E0);
  assign is_letter    = code_is_byte && lookup.hit;

  // ---------------------------------------------------------------- decoder
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else if (bus.clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    push_req    = 1'b0;
    push_letter = lookup.idx;
`ifdef SCAN_TYPEMATIC_FILTER_EN
    held_valid_next  = held_valid_reg;
    held_letter_next = held_letter_reg;
`endif
    if (bus.scan_valid) begin
      case (state_reg)
        IDLE: begin
          if (is_f0) begin
            state_next = BRK;
          end else if (is_e0) begin
            state_next = EXT;
          end else if (is_letter) begin
`ifdef SCAN_TYPEMATIC_FILTER_EN
            // Auto-repeat of the key still held down is not queued again.
            if (!(held_valid_reg && (held_letter_reg == lookup.idx))) begin
              push_req         = 1'b1;
              held_valid_next  = 1'b1;
              held_letter_next = lookup.idx;
            end
`else
            push_req = 1'b1;
`endif
          end
        end
        BRK: begin
`ifdef SCAN_TYPEMATIC_FILTER_EN
          if (is_letter && held_valid_reg && (held_letter_reg == lookup.idx)) begin
            held_valid_next = 1'b0;
          end
`endif
          state_next = IDLE;
        end
        EXT: begin
          state_next = is_f0 ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_TYPEMATIC_FILTER_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_valid_reg  <= 1'b0;
      held_letter_reg <= '0;
    end else if (bus.clear) begin
      held_valid_reg  <= 1'b0;
      held_letter_reg <= '0;
    end else begin
      held_valid_reg  <= held_valid_next;
      held_letter_reg <= held_letter_next;
    end
  end
`endif

  // ------------------------------------------------------------------- FIFO
  letter_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (bus.clear),
    .push    (push_req),
    .din     (push_letter),
    .pop     (bus.pop),
    .dout    (head_letter),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .dropped (fifo_dropped)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_reg <= 1'b0;
    end else if (bus.clear) begin
      overflow_reg <= 1'b0;
    end else if (fifo_dropped) begin
      overflow_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.letter    = head_letter;
  assign bus.out_valid = !fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_reg;

  generate
    for (genvar gi = 0; gi < NUM_LETTERS; gi++) begin : g_onehot
      assign bus.letter_onehot[gi] = !fifo_empty && (head_letter == LETTER_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_scan_letter_fifo.sv
// -----------------------------------------------------------------------------
// tb_scan_letter_fifo
// Directed scenarios with literal expectations followed by a randomized byte
// stream; a queue-based reference model is compared against the DUT on every
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_scan_letter_fifo;
  localparam int DEPTH  = 8;
  localparam int CODE_W = 8;

  logic clock;
  logic resetn;

  scan_letter_fifo_if #(.DEPTH(DEPTH), .CODE_W(CODE_W)) bus ();

  scan_letter_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Letter table A..Z in set-2 codes
  logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                             8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                             8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                             8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic int letter_of(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  // ------------------------------------------------------- reference model
  int  mq[$];
  bit  m_brk, m_ext, m_ovf;
  bit  m_held_v;
  int  m_held;
  int  m_idx;
  bit  m_push, m_pop;
  int  m_size;

  always @(posedge clock or negedge resetn) begin
    if (!resetn || bus.clear) begin
      mq.delete();
      m_brk = 0; m_ext = 0; m_ovf = 0; m_held_v = 0; m_held = 0;
    end else begin
      m_push = 0;
      m_idx  = letter_of(bus.scan_code);
      if (bus.scan_valid) begin
        if (m_brk) begin
          // byte after F0 is a release; a release of the held letter frees it
          if (!m_ext && m_idx >= 0 && m_held_v && m_held == m_idx) m_held_v = 0;
          m_brk = 0; m_ext = 0;
        end else if (bus.scan_code == 8'hF0) begin
          m_brk = 1;
        end else if (m_ext) begin
          m_ext = 0;
        end else if (bus.scan_code == 8'hE0) begin
          m_ext = 1;
        end else if (m_idx >= 0) begin
`ifdef SCAN_TYPEMATIC_FILTER_EN
          if (!(m_held_v && m_held == m_idx)) begin
            m_push = 1; m_held_v = 1; m_held = m_idx;
          end
`else
          m_push = 1;
`endif
        end
      end
      m_size = mq.size();
      m_pop  = bus.pop && (m_size > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (m_size == DEPTH && !m_pop) m_ovf = 1;
        else mq.push_back(m_idx);
      end
    end
  end

  // --------------------------------------------------------- compare process
  always @(negedge clock) begin
    int exp_letter;
    logic [25:0] exp_oh;
    exp_letter = (mq.size() > 0) ? mq[0] : 0;
    exp_oh     = (mq.size() > 0) ? (26'd1 << mq[0]) : 26'd0;
    checks += 5;
    if (bus.out_valid !== (mq.size() > 0)) begin
      failures++;
      $display("FAIL cyc_out_valid: got %0d expected %0d", bus.out_valid, mq.size() > 0);
    end
    if (bus.letter !== 5'(exp_letter)) begin
      failures++;
      $display("FAIL cyc_letter: got %0d expected %0d", bus.letter, exp_letter);
    end
    if (bus.letter_onehot !== exp_oh) begin
      failures++;
      $display("FAIL cyc_onehot: got %h expected %h", bus.letter_onehot, exp_oh);
    end
    if (bus.count !== 4'(mq.size())) begin
      failures++;
      $display("FAIL cyc_count: got %0d expected %0d", bus.count, mq.size());
    end
    if (bus.overflow !== m_ovf) begin
      failures++;
      $display("FAIL cyc_overflow: got %0d expected %0d", bus.overflow, m_ovf);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  // Drives one cycle of inputs just after the next rising edge.
  task automatic cyc(input bit v, input logic [7:0] code, input bit p, input bit clr);
    @(posedge clock);
    #1;
    bus.scan_valid = v;
    bus.scan_code  = code;
    bus.pop        = p;
    bus.clear      = clr;
  endtask

  task automatic idle();
    cyc(0, 8'h00, 0, 0);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int n_e;
    int r;
    logic [7:0] c;
    logic [7:0] last_c;
    bus.scan_valid = 0;
    bus.scan_code  = '0;
    bus.pop        = 0;
    bus.clear      = 0;
    resetn         = 0;
    #3;
    chk("reset_count", int'(bus.count), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_onehot", int'(bus.letter_onehot), 0);
    #9 resetn = 1;

    // A then B, no pop; one-cycle push latency
    cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'h32, 0, 0);
    chk("latency_out_valid", int'(bus.out_valid), 1);
    chk("latency_letter", int'(bus.letter), 0);
    idle();
    chk("ab_count", int'(bus.count), 2);
    chk("ab_letter", int'(bus.letter), 0);
    chk("ab_onehot", int'(bus.letter_onehot), 1);
    cyc(0, 8'h00, 1, 0);
    idle();
    chk("ab_pop_letter", int'(bus.letter), 1);
    chk("ab_pop_count", int'(bus.count), 1);

    // break and extended-break sequences push nothing
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hF0, 0, 0);
    cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'hE0, 0, 0);
    cyc(1, 8'hF0, 0, 0);
    cyc(1, 8'h1C, 0, 0);
    idle();
    chk("break_count", int'(bus.count), 0);
    cyc(1, 8'h1A, 0, 0);
    idle();
    chk("z_letter", int'(bus.letter), 25);
    chk("z_count", int'(bus.count), 1);

    // pop on empty is ignored
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 1, 0);
    idle();
    chk("empty_pop_count", int'(bus.count), 0);

    // overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) cyc(1, codes[i], 0, 0);
    idle();
    chk("ovf_count", int'(bus.count), 8);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_head", int'(bus.letter), 0);
    cyc(1, codes[9], 1, 0);
    idle();
    chk("full_pushpop_count", int'(bus.count), 8);
    chk("full_pushpop_head", int'(bus.letter), 1);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);
    idle();
    chk("full_tail_letter", int'(bus.letter), 9);

    // full push+pop without a prior overflow leaves the flag clear
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, codes[i + 10], 0, 0);
    cyc(1, codes[20], 1, 0);
    idle();
    chk("full_pp_noovf", int'(bus.overflow), 0);
    chk("full_pp_head", int'(bus.letter), 11);

    // auto-repeat sequence
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h24, 0, 0);
    cyc(1, 8'h24, 0, 0);
    cyc(1, 8'h24, 0, 0);
    cyc(1, 8'hF0, 0, 0);
    cyc(1, 8'h24, 0, 0);
    cyc(1, 8'h24, 0, 0);
    idle();
`ifdef SCAN_TYPEMATIC_FILTER_EN
    n_e = 2;
`else
    n_e = 4;
`endif
    chk("repeat_count", int'(bus.count), n_e);
    chk("repeat_letter", int'(bus.letter), 4);

    // asynchronous reset mid-sequence
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'h32, 0, 0);
    cyc(1, 8'h21, 0, 0);
    cyc(1, 8'hF0, 0, 0);
    idle();
    chk("pre_rst_count", int'(bus.count), 3);
    #3 resetn = 0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_letter", int'(bus.letter), 0);
    chk("arst_onehot", int'(bus.letter_onehot), 0);
    #2 resetn = 1;
    cyc(1, 8'h2D, 0, 0);
    idle();
    chk("post_rst_letter", int'(bus.letter), 17);
    chk("post_rst_count", int'(bus.count), 1);

    // clear wins over push and pop
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, codes[i], 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, codes[i], 0, 0);
    idle();
    chk("pre_clear_ovf", int'(bus.overflow), 1);
    cyc(0, 8'h00, 1, 0);
    idle();
    chk("pre_clear_count", int'(bus.count), 7);
    cyc(1, 8'h1C, 1, 1);
    idle();
    chk("clear_count", int'(bus.count), 0);
    chk("clear_out_valid", int'(bus.out_valid), 0);
    chk("clear_overflow", int'(bus.overflow), 0);

    // randomized stream
    last_c = 8'h1C;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4, 5: c = codes[$urandom_range(0, 25)];
        6:       c = 8'hF0;
        7:       c = 8'hE0;
        8:       c = 8'($urandom);
        default: c = last_c;
      endcase
      if (r <= 5) last_c = c;
      cyc($urandom_range(0, 99) < 60, c, $urandom_range(0, 2) == 0,
          $urandom_range(0, 199) == 0);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
